// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap controller: CSR address/cause types, the FSM
// state encoding and the latched trap record.
package trap_ctrl_pkg;

  typedef logic [4:0]  xcpt_code_t;
  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t   CSR_MTVAL_ADDR    = 12'h343;
  localparam logic [31:0] TRAP_TVEC_DEFAULT = 32'h0000_0100;

  typedef enum logic [2:0] {
    TRAP_IDLE,
    TRAP_TRAP,
    TRAP_MTVAL,
    TRAP_FLUSH,
    TRAP_REDIRECT
  } trap_state_t;

  typedef struct packed {
    xcpt_code_t  code;
    logic [31:0] pc;
    logic [31:0] value;
  } trap_info_t;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Fixed-priority encoder: the highest set request index (oldest stage) wins.
module xcpt_prio_enc #(
  parameter int NUM_SRC = 3,
  parameter int IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Ascending scan so the last (highest) set index overrides.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: picks the oldest pipeline exception, reports it to csr,
// writes mtval, flushes the pipe and redirects fetch (also handles mret).
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int          NUM_SRC      = 3,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] TVEC_ADDR    = TRAP_TVEC_DEFAULT
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic       [NUM_SRC-1:0]        src_xcpt_i,
  input  xcpt_code_t [NUM_SRC-1:0]        src_code_i,
  input  logic       [NUM_SRC-1:0][31:0]  src_pc_i,
  input  logic       [NUM_SRC-1:0][31:0]  src_value_i,
  input  logic                            mret_i,
  input  logic       [31:0]               mepc_i,
  output logic                            xcpt_o,
  output xcpt_code_t                      xcpt_code_o,
  output logic       [31:0]               xcpt_pc_o,
  output logic       [31:0]               xcpt_value_o,
  output logic                            csr_write_o,
  output csr_addr_t                       csr_addr_wr_o,
  output logic       [31:0]               csr_write_data_o,
  output logic                            flush_o,
  output logic                            redirect_valid_o,
  output logic       [31:0]               redirect_pc_o,
  output logic                            busy_o
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  trap_state_t   state;
  trap_info_t    info;
  logic [31:0]   target;
  logic [CW-1:0] cnt;

  logic          sel_vld;
  logic [IW-1:0] sel_idx;
  trap_info_t    sel_info;

  xcpt_prio_enc #(.NUM_SRC(NUM_SRC), .IW(IW)) u_prio (
    .req   (src_xcpt_i),
    .valid (sel_vld),
    .idx   (sel_idx)
  );

  assign sel_info = '{code:  src_code_i[sel_idx],
                      pc:    src_pc_i[sel_idx],
                      value: src_value_i[sel_idx]};

  // Outputs are registered alongside the state: each transition loads the
  // values that belong to the state being entered.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state            <= TRAP_IDLE;
      info             <= '0;
      target           <= '0;
      cnt              <= '0;
      xcpt_o           <= 1'b0;
      xcpt_code_o      <= '0;
      xcpt_pc_o        <= '0;
      xcpt_value_o     <= '0;
      csr_write_o      <= 1'b0;
      csr_addr_wr_o    <= '0;
      csr_write_data_o <= '0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      busy_o           <= 1'b0;
    end else begin
      xcpt_o           <= 1'b0;
      xcpt_code_o      <= '0;
      xcpt_pc_o        <= '0;
      xcpt_value_o     <= '0;
      csr_write_o      <= 1'b0;
      csr_addr_wr_o    <= '0;
      csr_write_data_o <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      flush_o          <= 1'b1;
      busy_o           <= 1'b1;
      unique case (state)
        TRAP_IDLE: begin
          if (sel_vld) begin
            state        <= TRAP_TRAP;
            info         <= sel_info;
            target       <= TVEC_ADDR;
            xcpt_o       <= 1'b1;
            xcpt_code_o  <= sel_info.code;
            xcpt_pc_o    <= sel_info.pc;
            xcpt_value_o <= sel_info.value;
          end else if (mret_i) begin
            state  <= TRAP_FLUSH;
            target <= mepc_i;
            cnt    <= CNT_INIT;
          end else begin
            flush_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        end
        TRAP_TRAP: begin
          state            <= TRAP_MTVAL;
          csr_write_o      <= 1'b1;
          csr_addr_wr_o    <= CSR_MTVAL_ADDR;
          csr_write_data_o <= info.value;
        end
        TRAP_MTVAL: begin
          state <= TRAP_FLUSH;
          cnt   <= CNT_INIT;
        end
        TRAP_FLUSH: begin
          if (cnt == '0) begin
            state            <= TRAP_REDIRECT;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= target;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TRAP_REDIRECT: begin
          state   <= TRAP_IDLE;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state   <= TRAP_IDLE;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, mret, priority, busy-ignore and
// reset-abort sequences checked cycle by cycle against hand-derived values.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam int          NS   = 3;
  localparam int          FC   = 2;
  localparam logic [31:0] TVEC = 32'h0000_0100;

  logic                   clk_i = 1'b0;
  logic                   rstn_i;
  logic       [NS-1:0]    src_xcpt_i;
  xcpt_code_t [NS-1:0]    src_code_i;
  logic [NS-1:0][31:0]    src_pc_i;
  logic [NS-1:0][31:0]    src_value_i;
  logic                   mret_i;
  logic [31:0]            mepc_i;
  logic                   xcpt_o;
  xcpt_code_t             xcpt_code_o;
  logic [31:0]            xcpt_pc_o;
  logic [31:0]            xcpt_value_o;
  logic                   csr_write_o;
  csr_addr_t              csr_addr_wr_o;
  logic [31:0]            csr_write_data_o;
  logic                   flush_o;
  logic                   redirect_valid_o;
  logic [31:0]            redirect_pc_o;
  logic                   busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  trap_ctrl #(.NUM_SRC(NS), .FLUSH_CYCLES(FC), .TVEC_ADDR(TVEC)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .src_xcpt_i       (src_xcpt_i),
    .src_code_i       (src_code_i),
    .src_pc_i         (src_pc_i),
    .src_value_i      (src_value_i),
    .mret_i           (mret_i),
    .mepc_i           (mepc_i),
    .xcpt_o           (xcpt_o),
    .xcpt_code_o      (xcpt_code_o),
    .xcpt_pc_o        (xcpt_pc_o),
    .xcpt_value_o     (xcpt_value_o),
    .csr_write_o      (csr_write_o),
    .csr_addr_wr_o    (csr_addr_wr_o),
    .csr_write_data_o (csr_write_data_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One full comparison of every output for the current cycle.
  task automatic expect_cyc(input string tag, input bit x, input xcpt_code_t code,
                            input logic [31:0] pc, input logic [31:0] val,
                            input bit wr, input logic [31:0] wdata, input bit fl,
                            input bit rv, input logic [31:0] rpc, input bit busy);
    chk({tag, ".xcpt"},  32'(xcpt_o), 32'(x));
    chk({tag, ".code"},  32'(xcpt_code_o), 32'(code));
    chk({tag, ".pc"},    xcpt_pc_o, pc);
    chk({tag, ".val"},   xcpt_value_o, val);
    chk({tag, ".wr"},    32'(csr_write_o), 32'(wr));
    chk({tag, ".addr"},  32'(csr_addr_wr_o), wr ? 32'h343 : 32'h0);
    chk({tag, ".wdata"}, csr_write_data_o, wdata);
    chk({tag, ".flush"}, 32'(flush_o), 32'(fl));
    chk({tag, ".rv"},    32'(redirect_valid_o), 32'(rv));
    chk({tag, ".rpc"},   redirect_pc_o, rpc);
    chk({tag, ".busy"},  32'(busy_o), 32'(busy));
  endtask

  task automatic expect_idle(input string tag);
    expect_cyc(tag, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_in();
    src_xcpt_i = '0;
    mret_i     = 1'b0;
  endtask

  // Request must already be on the inputs; noise keeps requests/mret
  // asserted throughout the busy window to prove they are ignored.
  task automatic run_xcpt(input string tag, input xcpt_code_t c, input logic [31:0] pc,
                          input logic [31:0] val, input bit noise);
    step();
    if (noise) begin
      src_xcpt_i = '1;
      mret_i     = 1'b1;
      mepc_i     = 32'hBAD0_0000;
    end else clear_in();
    expect_cyc({tag, ".trap"}, 1, c, pc, val, 0, 0, 1, 0, 0, 1);
    step();
    expect_cyc({tag, ".mtval"}, 0, 0, 0, 0, 1, val, 1, 0, 0, 1);
    for (int k = 0; k < FC; k++) begin
      step();
      expect_cyc({tag, ".flush"}, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    end
    step();
    expect_cyc({tag, ".redir"}, 0, 0, 0, 0, 0, 0, 1, 1, TVEC, 1);
    clear_in();
    step();
    expect_idle({tag, ".idle"});
  endtask

  initial begin
    rstn_i      = 1'b0;
    src_xcpt_i  = '0;
    src_code_i  = '0;
    src_pc_i    = '0;
    src_value_i = '0;
    mret_i      = 1'b0;
    mepc_i      = '0;

    // Reset held for two cycles with inputs toggling.
    for (int k = 0; k < 2; k++) begin
      src_xcpt_i  = NS'($urandom);
      src_code_i  = 15'($urandom);
      src_pc_i    = {$urandom, $urandom, $urandom};
      src_value_i = {$urandom, $urandom, $urandom};
      mret_i      = ~mret_i;
      mepc_i      = $urandom;
      step();
      expect_idle("rst");
    end
    clear_in();
    rstn_i = 1'b1;
    step();
    expect_idle("post_rst");

    // Single memory exception.
    src_code_i[2] = 5'd5; src_pc_i[2] = 32'h0000_0040; src_value_i[2] = 32'hDEAD_0004;
    src_xcpt_i = 3'b100;
    run_xcpt("mem", 5'd5, 32'h0000_0040, 32'hDEAD_0004, 0);

    // Fetch + decode together: decode (index 1) wins, fetch is dropped.
    src_code_i[0] = 5'd1; src_pc_i[0] = 32'h0000_0010; src_value_i[0] = 32'h0000_0011;
    src_code_i[1] = 5'd2; src_pc_i[1] = 32'h0000_0020; src_value_i[1] = 32'h0000_0022;
    src_xcpt_i = 3'b011;
    run_xcpt("prio", 5'd2, 32'h0000_0020, 32'h0000_0022, 0);
    step();
    expect_idle("prio.lost");

    // mret: flush, then redirect to mepc, no csr traffic.
    mret_i = 1'b1; mepc_i = 32'h0000_0200;
    step();
    clear_in();
    for (int k = 0; k < FC; k++) begin
      expect_cyc("mret.flush", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      step();
    end
    expect_cyc("mret.redir", 0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0200, 1);
    step();
    expect_idle("mret.idle");

    // Exception and mret together: exception wins.
    src_code_i[0] = 5'd3; src_pc_i[0] = 32'h0000_0080; src_value_i[0] = 32'h0000_1234;
    src_xcpt_i = 3'b001; mret_i = 1'b1; mepc_i = 32'h0000_0300;
    run_xcpt("both", 5'd3, 32'h0000_0080, 32'h0000_1234, 0);

    // Requests and mret while busy are ignored.
    src_code_i[1] = 5'd7; src_pc_i[1] = 32'h0000_00A0; src_value_i[1] = 32'hCAFE_0001;
    src_xcpt_i = 3'b010;
    run_xcpt("busy", 5'd7, 32'h0000_00A0, 32'hCAFE_0001, 1);

    // Back-to-back: request present at the first IDLE edge after REDIRECT.
    src_xcpt_i = 3'b100;
    run_xcpt("b2b", 5'd5, 32'h0000_0040, 32'hDEAD_0004, 0);

    // Reset mid-FLUSH on the exception path: no redirect afterwards.
    src_xcpt_i = 3'b100;
    step(); clear_in();
    step();
    step();
    expect_cyc("rstx.flush", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    rstn_i = 1'b0;
    step();
    expect_idle("rstx.rst");
    rstn_i = 1'b1;
    for (int k = 0; k < FC + 2; k++) begin
      step();
      expect_idle("rstx.after");
    end

    // Reset mid-FLUSH on the mret path.
    mret_i = 1'b1; mepc_i = 32'h0000_0400;
    step(); clear_in();
    expect_cyc("rstm.flush", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    rstn_i = 1'b0;
    step();
    expect_idle("rstm.rst");
    rstn_i = 1'b1;
    for (int k = 0; k < FC + 2; k++) begin
      step();
      expect_idle("rstm.after");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
